instr_encoder: RTL

//  Inverse of the main opcode/control decode: packs instruction fields into 32-bit RV32I words.

---
 rtl/instr_encoder_if.sv | 34 +++
 rtl/instr_encoder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// Field-bundle input, encoded-word output and status lines of the RV32I instruction encoder.
// The slave side is the encoder; the master side is the producer/sink that drives it.
interface instr_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [2:0]        in_funct3;
    logic              in_funct7b5;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic              full;

    modport master (
        output clear, in_valid, in_kind, in_funct3, in_funct7b5,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err, full
    );

    modport slave (
        input  clear, in_valid, in_kind, in_funct3, in_funct7b5,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err, full
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs lw/sw/R/beq/I-ALU/jal/auipc field bundles into RV32I words and streams them
// with sequential word addresses through a single output register.
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic           clk,
    input  logic           reset,
    instr_encoder_if.slave bus
);
    localparam logic [2:0] K_LW    = 3'd0;
    localparam logic [2:0] K_SW    = 3'd1;
    localparam logic [2:0] K_R     = 3'd2;
    localparam logic [2:0] K_BEQ   = 3'd3;
    localparam logic [2:0] K_IALU  = 3'd4;
    localparam logic [2:0] K_JAL   = 3'd5;
    localparam logic [2:0] K_AUIPC = 3'd6;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_BRANCH= 7'b1100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_err;
    logic [ADDR_W:0]   r_count;

    logic [31:0] w_imm;
    logic [31:0] w_instr;
    logic        w_legal;
    logic        w_fits12;
    logic        w_fits13;
    logic        w_fits21;
    logic        w_shift;
    logic        w_full;
    logic        w_in_ready;
    logic        w_accept;

    assign w_imm    = bus.in_imm;
    assign w_fits12 = (w_imm[31:11] == {21{w_imm[11]}});
    assign w_fits13 = (w_imm[31:12] == {20{w_imm[12]}});
    assign w_fits21 = (w_imm[31:20] == {12{w_imm[20]}});
    assign w_shift  = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101);

    // The counter's top bit doubles as the full flag: it is set exactly when 2**ADDR_W words went out.
    assign w_full     = r_count[ADDR_W];
    assign w_in_ready = ~reset & ~bus.clear & ~w_full & (~r_out_valid | bus.out_ready);
    assign w_accept   = bus.in_valid & w_in_ready;

    always_comb begin
        w_instr = '0;
        w_legal = 1'b0;
        case (bus.in_kind)
            K_LW: begin
                w_legal = w_fits12;
                w_instr = {w_imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, OP_LOAD};
            end
            K_SW: begin
                w_legal = w_fits12;
                w_instr = {w_imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010, w_imm[4:0], OP_STORE};
            end
            K_R: begin
                w_legal = 1'b1;
                w_instr = {1'b0, bus.in_funct7b5, 5'b00000, bus.in_rs2, bus.in_rs1,
                           bus.in_funct3, bus.in_rd, OP_REG};
            end
            K_BEQ: begin
                w_legal = w_fits13 & ~w_imm[0];
                w_instr = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, 3'b000,
                           w_imm[4:1], w_imm[11], OP_BRANCH};
            end
            K_IALU: begin
                w_legal = w_fits12 & (~w_shift | (w_imm[11:5] == 7'd0));
                if (bus.in_funct3 == 3'b101) begin
                    w_instr = {1'b0, bus.in_funct7b5, 5'b00000, w_imm[4:0], bus.in_rs1,
                               bus.in_funct3, bus.in_rd, OP_IMM};
                end else begin
                    w_instr = {w_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_IMM};
                end
            end
            K_JAL: begin
                w_legal = w_fits21 & ~w_imm[0];
                w_instr = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.in_rd, OP_JAL};
            end
            K_AUIPC: begin
                w_legal = (w_imm[11:0] == 12'd0);
                w_instr = {w_imm[31:12], bus.in_rd, OP_AUIPC};
            end
            default: begin
                w_legal = 1'b0;
                w_instr = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_addr  <= '0;
            r_err       <= 1'b0;
            r_count     <= '0;
        end else if (bus.clear) begin
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_count     <= '0;
        end else begin
            // Illegal bundles are consumed but only leave an err pulse behind.
            r_err <= w_accept & ~w_legal;
            if (w_accept & w_legal) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_instr;
                r_out_addr  <= r_count[ADDR_W-1:0];
                r_count     <= r_count + CNT_ONE;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_instr = r_out_instr;
    assign bus.out_addr  = r_out_addr;
    assign bus.err       = r_err;
    assign bus.full      = w_full;
endmodule
